// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
//
// Read-side sequencer for a single-port BRAM that has a registered read port
// with one cycle of latency. A start command captures a base address and a
// word count. The block then reads that many consecutive words and presents
// them downstream as a valid/ready stream, with m_last_o marking the final
// word. Addresses wrap modulo RAM_DEPTH.
//
// Handshake: a word transfers on a rising edge where m_valid_o && m_ready_i.
// Once m_valid_o is high, m_data_o and m_last_o hold until that transfer
// happens.
//
// Ports:
//   clk_i, rst_i       clock; asynchronous active-high reset
//   start_i            command strobe, sampled only while idle
//   base_addr_i        first read address, captured with start_i
//   len_i              word count 0..RAM_DEPTH, captured with start_i
//   busy_o             transfer in progress (READ, DRAIN, FIN)
//   done_o             one-cycle pulse at transfer end
//   mem_en_o           BRAM enable; high only on read-issue cycles
//   mem_we_o           BRAM write enable, always 0
//   mem_addr_o         BRAM address
//   mem_data_i         BRAM registered read data
//   m_data_o           stream data
//   m_valid_o          stream valid
//   m_ready_i          stream ready
//   m_last_o           final word of the transfer
// ---------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [RAM_ADDR_BITS-1:0] base_addr_i,
    input  logic [RAM_ADDR_BITS:0]   len_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     mem_en_o,
    output logic                     mem_we_o,
    output logic [RAM_ADDR_BITS-1:0] mem_addr_o,
    input  logic [RAM_WIDTH-1:0]     mem_data_i,
    output logic [RAM_WIDTH-1:0]     m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic                     m_last_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [RAM_ADDR_BITS-1:0] addr;
    logic [RAM_ADDR_BITS:0]   remaining;
    logic                     inflight;
    logic                     inflight_last;

    // Two-entry output FIFO.
    logic [RAM_WIDTH-1:0] fifo_data [2];
    logic [1:0]           fifo_last;
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           fifo_count;

    logic issue;
    logic push;
    logic pop;
    logic credit_ok;

    assign pop  = m_valid_o & m_ready_i;
    assign push = inflight;

    // credit = 2 - fifo_count - inflight + pop; a read may issue when credit > 0,
    // i.e. fifo_count + inflight <= 1 + pop. This bounds buffered plus
    // in-flight words to two, so the FIFO cannot overflow.
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop});

    assign issue = (state == READ) && (remaining != '0) && credit_ok;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (len_i == '0) ? FIN : READ;
                end
            end
            READ: begin
                if (issue && (remaining == 1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The word tagged last is the final one of the transfer, so its
                // handshake means the FIFO and the read pipeline are both empty.
                if (pop && m_last_o) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_o = (state != IDLE);
    assign done_o = (state == FIN);

    // ------------------------------------------------------------------
    // Address / count / in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if ((state == IDLE) && start_i) begin
                addr      <= base_addr_i;
                remaining <= len_i;
            end else if (issue) begin
                // Natural wrap of the address width gives RAM_DEPTH-1 -> 0.
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            // Data appears on mem_data_i the cycle after an issue; inflight
            // stays set only while back-to-back reads keep issuing.
            inflight <= issue;
            if (issue) begin
                inflight_last <= (remaining == 1);
            end
        end
    end

    assign mem_en_o   = issue;
    assign mem_we_o   = 1'b0;
    assign mem_addr_o = addr;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
            end
            fifo_last  <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_data_i;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign m_valid_o = (fifo_count != '0);
    // Gate with valid so no stale entry is visible while the FIFO is empty.
    assign m_data_o  = m_valid_o ? fifo_data[rd_ptr] : '0;
    assign m_last_o  = m_valid_o & fifo_last[rd_ptr];

endmodule

// File: tb/tb_bram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_stream_reader
//
// Bench for bram_stream_reader. It has a BRAM model preloaded with
// mem[k] = k mod 256. A driver issues directed commands and pushes the
// expected addresses and stream words into queues. A monitor checks every
// read issue and every stream handshake against those queues.
// ---------------------------------------------------------------------------
module tb_bram_stream_reader;

  localparam int W     = 8;
  localparam int AB    = 10;
  localparam int DEPTH = 1 << AB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [AB-1:0] base_addr;
  logic [AB:0]   len;
  logic          busy, done, mem_en, mem_we;
  logic [AB-1:0] mem_addr;
  logic [W-1:0]  mem_data;
  logic [W-1:0]  m_data;
  logic          m_valid, m_ready, m_last;

  bram_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .base_addr_i(base_addr),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_data_i (mem_data),
    .m_data_o   (m_data),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_last_o   (m_last)
  );

  // BRAM model: registered read, one cycle of latency.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_data <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W:0]    exp_q[$];
  logic [AB-1:0] addr_q[$];
  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver-owned state ----------------
  int s = 0;          // cycle number of "cycle 0" of the current command
  int xfer_id = 0;
  int rmode = 0;      // 0: ready=1, 1: toggling, 2: 8-cycle stall, 3: ready=0
  int en_base, hs_base, done_base;

  // ---------------- monitor-owned state ----------------
  int en_cnt = 0, hs_cnt = 0, done_cnt = 0;
  int en_id = 0, valid_id = 0;
  int first_en = -1, first_valid = -1, last_hs = -1, done_cyc = -1;
  logic       hold_pend = 1'b0;
  logic [W:0] hold_val;

  // Monitor samples mid-cycle, opposite the active edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
      en_cnt    = hs_cnt;
    end else begin
      if (mem_en) begin
        en_cnt++;
        if (en_id != xfer_id) begin
          en_id    = xfer_id;
          first_en = cyc;
        end
        check("mem_we", mem_we, 0);
        if (addr_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_read: got addr %0d expected no read", mem_addr);
        end else begin
          check("read_addr", mem_addr, addr_q.pop_front());
        end
      end
      if (m_valid && valid_id != xfer_id) begin
        valid_id    = xfer_id;
        first_valid = cyc;
      end
      if (hold_pend) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", {m_last, m_data}, hold_val);
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (m_last) last_hs = cyc;
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_word: got %0d expected no word", {m_last, m_data});
        end else begin
          check("stream_word", {m_last, m_data}, exp_q.pop_front());
        end
      end
      if (mem_en) check("reads_ahead_le2", (en_cnt - hs_cnt) <= 2, 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      hold_pend = m_valid && !m_ready;
      hold_val  = {m_last, m_data};
    end
  end

  // Ready driver: updates 1 time unit after each rising edge.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = cyc[0];
        2: m_ready = !((cyc >= s + 4) && (cyc <= s + 11));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input int a, input bit last);
    logic [AB-1:0] aa;
    aa = a[AB-1:0];
    addr_q.push_back(aa);
    exp_q.push_back({last, mem[aa]});
  endtask

  task automatic start_xfer(input int b, input int n, input bit gen_exp);
    @(posedge clk);
    #1;
    xfer_id++;
    en_base   = en_cnt;
    hs_base   = hs_cnt;
    done_base = done_cnt;
    s         = cyc;
    base_addr = b[AB-1:0];
    len       = n[AB:0];
    start     = 1'b1;
    if (gen_exp) begin
      for (int k = 0; k < n; k++) push_word((b + k) % DEPTH, k == n - 1);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget && done_cnt == done_base; i++) @(negedge clk);
    if (done_cnt == done_base) begin
      vecs++;
      errs++;
      $display("FAIL %s_timeout: got no done_o in %0d cycles expected done_o", name, budget);
    end
    repeat (3) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt - done_base, 1);
    check({name, "_exp_q_empty"}, exp_q.size(), 0);
    check({name, "_addr_q_empty"}, addr_q.size(), 0);
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_mem_en"}, mem_en, 0);
    check({name, "_mem_addr"}, mem_addr, 0);
    check({name, "_m_data"}, m_data, 0);
    check({name, "_m_valid"}, m_valid, 0);
    check({name, "_m_last"}, m_last, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = k[W-1:0];
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    #3;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // base=5 len=4, ready held high: words 5..8 in cycles 3..6, done in 7.
    rmode = 0;
    start_xfer(5, 4, 1);
    wait_done("basic", 100);
    check("basic_first_en_cycle", first_en - s, 1);
    check("basic_first_valid_cycle", first_valid - s, 3);
    check("basic_last_cycle", last_hs - s, 6);
    check("basic_done_cycle", done_cyc - s, 7);
    check("basic_reads", en_cnt - en_base, 4);
    check("basic_words", hs_cnt - hs_base, 4);

    // Same transfer with ready toggling.
    rmode = 1;
    start_xfer(5, 4, 1);
    wait_done("toggle", 100);
    check("toggle_reads", en_cnt - en_base, 4);
    check("toggle_words", hs_cnt - hs_base, 4);
    check("toggle_done_after_last", done_cyc - last_hs, 1);

    // Same transfer with an 8-cycle stall in the middle.
    rmode = 2;
    start_xfer(5, 4, 1);
    wait_done("stall", 100);
    check("stall_reads", en_cnt - en_base, 4);
    check("stall_words", hs_cnt - hs_base, 4);
    check("stall_done_after_last", done_cyc - last_hs, 1);

    // Address wrap: 1022,1023,0,1 -> data 254,255,0,1.
    rmode = 0;
    addr_q.push_back(10'd1022); exp_q.push_back({1'b0, 8'd254});
    addr_q.push_back(10'd1023); exp_q.push_back({1'b0, 8'd255});
    addr_q.push_back(10'd0);    exp_q.push_back({1'b0, 8'd0});
    addr_q.push_back(10'd1);    exp_q.push_back({1'b1, 8'd1});
    start_xfer(1022, 4, 0);
    wait_done("wrap", 100);
    check("wrap_words", hs_cnt - hs_base, 4);

    // len=0: done in cycle 1, no reads, no stream output.
    start_xfer(0, 0, 1);
    wait_done("len0", 20);
    check("len0_done_cycle", done_cyc - s, 1);
    check("len0_reads", en_cnt - en_base, 0);
    check("len0_no_valid", valid_id == xfer_id, 0);

    // Full-depth transfer: 1024 words, last only on the final one.
    start_xfer(0, DEPTH, 1);
    wait_done("full", 1200);
    check("full_reads", en_cnt - en_base, DEPTH);
    check("full_words", hs_cnt - hs_base, DEPTH);
    check("full_last_cycle", last_hs - s, DEPTH + 2);

    // Second start during a busy transfer is ignored.
    start_xfer(50, 6, 1);
    @(posedge clk);
    #1;
    base_addr = 10'd900;
    len       = 11'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start", 100);
    check("busy_start_reads", en_cnt - en_base, 6);
    check("busy_start_words", hs_cnt - hs_base, 6);

    // Asynchronous reset with the FIFO full, then a clean restart.
    rmode = 3;
    start_xfer(100, 6, 1);
    repeat (4) @(negedge clk);
    check("pre_reset_valid", m_valid, 1);
    check("pre_reset_head", m_data, 100);
    check("pre_reset_no_read", mem_en, 0);
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    rmode = 0;
    start_xfer(300, 3, 1);
    wait_done("post_reset", 100);
    check("post_reset_words", hs_cnt - hs_base, 3);
    check("post_reset_first_valid", first_valid - s, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected finish before %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side sequencer that drives a single-port BRAM with a registered, 1-cycle-latency read port and enable gating.
- On a start command, reads len consecutive words from a base address and presents them as a valid/ready stream with backpressure and a last flag.
- Sits between a RAM instance and downstream stream consumers such as a UART transmitter or a display feeder.

Parameters:
- RAM_WIDTH, 8, data word width in bits.
- RAM_ADDR_BITS, 10, address width; RAM_DEPTH = 2**RAM_ADDR_BITS.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  command strobe; sampled only when busy_o=0.
- base_addr_i  in  RAM_ADDR_BITS  first read address; captured with start_i.
- len_i  in  RAM_ADDR_BITS+1  word count, 0..RAM_DEPTH; captured with start_i.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse at transfer end.
- mem_en_o  out  1  BRAM enable; high only on cycles that issue a read.
- mem_we_o  out  1  BRAM write enable; tied 0.
- mem_addr_o  out  RAM_ADDR_BITS  BRAM address.
- mem_data_i  in  RAM_WIDTH  BRAM registered read data.
- m_data_o  out  RAM_WIDTH  stream data.
- m_valid_o  out  1  stream valid.
- m_ready_i  in  1  stream ready.
- m_last_o  out  1  high with the final word of a transfer.

Behaviour:
- Reset (async, any time, including mid-transfer): state IDLE; output FIFO emptied; counters, in-flight flag and captured command cleared.
- Reset values: busy_o, done_o, mem_en_o, m_valid_o and m_last_o are 0; mem_addr_o and m_data_o are 0. The BRAM is not touched during reset.
- FSM states:
  - IDLE: start_i=1 captures base/len and moves to READ; if len=0, moves to FIN instead.
  - READ: issues reads. Moves to DRAIN when the last read issues.
  - DRAIN: waits for the in-flight read and the FIFO to empty through the final handshake, then moves to FIN.
  - FIN: done_o=1 for one cycle, then IDLE.
- busy_o is 1 in READ, DRAIN and FIN.
- Read issue:
  - In READ, mem_en_o=1 when remaining>0 and credit>0.
  - credit = 2 - fifo_count - inflight + (m_valid_o & m_ready_i).
  - The output buffer is a 2-entry FIFO.
- Issue effects:
  - mem_addr_o is the current address; after each issue it becomes (addr+1) mod RAM_DEPTH, so a read at RAM_DEPTH-1 is followed by a read at 0.
  - remaining decrements on each issue.
- In-flight handling:
  - inflight is set on the edge ending an issue cycle.
  - On the next edge, mem_data_i is pushed into the FIFO, tagged last if it was the final word.
  - inflight is then cleared unless a new read issued in that cycle.
- Timing:
  - start_i high in cycle 0 gives mem_en_o high in cycle 1 and m_valid_o high in cycle 3.
  - With m_ready_i held at 1, throughput is one word per cycle.
  - done_o pulses the cycle after the handshake carrying m_last_o.
  - len=0: done_o in cycle 1, no mem_en_o and no stream output.
- Stream rules:
  - m_valid_o=1 whenever the FIFO is non-empty.
  - m_data_o and m_last_o are the FIFO head.
  - Once m_valid_o=1, m_data_o and m_last_o hold stable until the handshake.
  - A push and a pop in the same cycle keep the FIFO count.
  - The FIFO never overflows, because credit ensures at most 2 words are buffered or in flight.
- start_i while busy_o=1 is ignored; the command is not queued.
- len=RAM_DEPTH reads every word once, starting at base and wrapping.

Test Plan:
- BRAM preloaded mem[k]=k. start, base=5, len=4, m_ready_i=1 -> words 5,6,7,8 on consecutive cycles from cycle 3; m_last_o with 8; done_o one cycle later; exactly 4 mem_en_o cycles.
- Same transfer with m_ready_i toggling 1010... and with an 8-cycle stall mid-transfer -> no loss or duplication; m_data_o stable while stalled; at most 2 reads ahead of the consumer.
- base=1022, len=4, RAM_ADDR_BITS=10 -> addresses 1022,1023,0,1 and data 254,255,0,1 (k mod 256 for an 8-bit width).
- len=0 -> done_o in cycle 1, m_valid_o and mem_en_o never high; then len=1024, base=0 -> 1024 words, m_last_o only on the 1024th.
- start_i pulsed again during a len=6 transfer with base=50 -> ignored; output is only the original 6 words.
- rst_i asserted asynchronously mid-transfer with the FIFO full -> all outputs 0 immediately. A new start after release begins cleanly, with no stale words emitted.
